// File: rtl/psum_read_controller.sv
`timescale 1ns/1ps
// Psum read controller.
// Finds the bank holding a given operation's psums, streams its words
// through a 2-entry output FIFO, then pulses that bank's clear.
module psum_read_controller #(
    parameter int TOTAL_BANK_COUNT = 6,
    parameter int SMALL_BANK_COUNT = 3,
    parameter int SMALL_DEPTH      = 16,
    parameter int ADDR_WIDTH       = 8,
    parameter int GPR_WIDTH        = 6,
    parameter int DATA_WIDTH       = 32,
    parameter int BANK_INDEX_WIDTH = $clog2(TOTAL_BANK_COUNT)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  rd_req,
    input  logic [GPR_WIDTH-1:0]                  rd_op_id,
    input  logic [ADDR_WIDTH-1:0]                 rd_length,
    output logic                                  rd_ack,
    output logic                                  rd_done,
    output logic                                  rd_error,
    output logic                                  busy,
    input  logic [GPR_WIDTH*TOTAL_BANK_COUNT-1:0] bank_op_id_flat,
    input  logic [TOTAL_BANK_COUNT-1:0]           bank_valid_in,
    output logic [TOTAL_BANK_COUNT-1:0]           bank_clear_out,
    output logic                                  mem_rd_en,
    output logic [BANK_INDEX_WIDTH-1:0]           mem_rd_bank,
    output logic [ADDR_WIDTH-1:0]                 mem_rd_addr,
    input  logic [DATA_WIDTH-1:0]                 mem_rd_data,
    output logic                                  out_valid,
    output logic [DATA_WIDTH-1:0]                 out_data,
    output logic                                  out_last,
    input  logic                                  out_ready
);

    typedef enum logic [2:0] {IDLE, SEARCH, READ, FLUSH, CLEAR, DONE} state_t;
    state_t state;

    logic [GPR_WIDTH-1:0]        op_id_q;
    logic [ADDR_WIDTH-1:0]       len_q;
    logic                        match_found;
    logic [BANK_INDEX_WIDTH-1:0] match_idx;
    logic                        search_err;

    logic [DATA_WIDTH-1:0] fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  issue_last;

    // Lowest-index valid bank whose op ID matches the latched request
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int unsigned j = 0; j < TOTAL_BANK_COUNT; j++) begin
            if (!match_found && bank_valid_in[j] &&
                bank_op_id_flat[j*GPR_WIDTH +: GPR_WIDTH] == op_id_q) begin
                match_found = 1'b1;
                match_idx   = BANK_INDEX_WIDTH'(j);
            end
        end
    end

    // Request rejection: miss, empty drain, or small bank asked for too many words
    always_comb begin
        search_err = !match_found || (len_q == '0) ||
                     ((32'(match_idx) < SMALL_BANK_COUNT) && (32'(len_q) > SMALL_DEPTH));
    end

    // Read issue gated so FIFO words plus in-flight reads never exceed 2
    always_comb begin
        pop        = out_valid && out_ready;
        push       = inflight_q;
        issue      = (state == READ) &&
                     (({1'b0, count} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
        issue_last = issue && (mem_rd_addr == len_q - ADDR_WIDTH'(1));
        mem_rd_en  = issue;
        out_valid  = (count != 2'd0);
        out_data   = fifo_data[rd_ptr];
        out_last   = out_valid && fifo_last[rd_ptr];
        busy       = (state != IDLE);
    end

    // Control FSM with registered handshake, bank index, address and clear outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            op_id_q        <= '0;
            len_q          <= '0;
            mem_rd_bank    <= '0;
            mem_rd_addr    <= '0;
            rd_ack         <= 1'b0;
            rd_done        <= 1'b0;
            rd_error       <= 1'b0;
            bank_clear_out <= '1;
        end else begin
            rd_ack         <= 1'b0;
            rd_done        <= 1'b0;
            rd_error       <= 1'b0;
            bank_clear_out <= '1;
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        op_id_q     <= rd_op_id;
                        len_q       <= rd_length;
                        mem_rd_addr <= '0;
                        rd_ack      <= 1'b1;
                        state       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (search_err) begin
                        rd_done  <= 1'b1;
                        rd_error <= 1'b1;
                        state    <= DONE;
                    end else begin
                        mem_rd_bank <= match_idx;
                        state       <= READ;
                    end
                end
                READ: begin
                    if (issue) begin
                        mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(1);
                        if (issue_last) state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (pop && out_last) begin
                        bank_clear_out <= ~(TOTAL_BANK_COUNT'(1) << mem_rd_bank);
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    rd_done <= 1'b1;
                    state   <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Read-return capture and 2-entry output FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            rd_ptr          <= 1'b0;
            wr_ptr          <= 1'b0;
            count           <= '0;
            fifo_data[0]    <= '0;
            fifo_data[1]    <= '0;
            fifo_last       <= '0;
        end else begin
            inflight_q      <= issue;
            inflight_last_q <= issue_last;
            if (push) begin
                fifo_data[wr_ptr] <= mem_rd_data;
                fifo_last[wr_ptr] <= inflight_last_q;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_psum_read_controller.sv
`timescale 1ns/1ps
// Directed self-checking bench for psum_read_controller.
module tb_psum_read_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_req;
    logic [5:0]  rd_op_id;
    logic [7:0]  rd_length;
    logic        rd_ack, rd_done, rd_error, busy;
    logic [35:0] bank_op_id_flat;
    logic [5:0]  bank_valid_in;
    logic [5:0]  bank_clear_out;
    logic        mem_rd_en;
    logic [2:0]  mem_rd_bank;
    logic [7:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    int checks = 0;
    int errors = 0;

    psum_read_controller #(
        .TOTAL_BANK_COUNT(6), .SMALL_BANK_COUNT(3), .SMALL_DEPTH(16),
        .ADDR_WIDTH(8), .GPR_WIDTH(6), .DATA_WIDTH(32)
    ) dut (
        .clk(clk), .reset(reset), .rd_req(rd_req), .rd_op_id(rd_op_id),
        .rd_length(rd_length), .rd_ack(rd_ack), .rd_done(rd_done),
        .rd_error(rd_error), .busy(busy), .bank_op_id_flat(bank_op_id_flat),
        .bank_valid_in(bank_valid_in), .bank_clear_out(bank_clear_out),
        .mem_rd_en(mem_rd_en), .mem_rd_bank(mem_rd_bank), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] pat(input logic [2:0] b, input logic [7:0] a);
        return 32'hC0DE_0000 | {16'h0000, 5'h00, b, a};
    endfunction

    // Bank memory model: one-cycle read latency
    always @(posedge clk) mem_rd_data <= mem_rd_en ? pat(mem_rd_bank, mem_rd_addr) : 32'h0;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int j, input logic [5:0] op, input logic v);
        bank_op_id_flat[j*6 +: 6] = op;
        bank_valid_in[j]          = v;
    endtask

    task automatic test_reset();
        reset = 1'b1; rd_req = 1'b0; rd_op_id = '0; rd_length = '0; out_ready = 1'b1;
        bank_op_id_flat = '0; bank_valid_in = '0;
        next_cycle();
        next_cycle();
        #1;
        checks++;
        if ({rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000000",
                     {rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last});
        end
        checks++;
        if (mem_rd_addr !== 8'd0 || mem_rd_bank !== 3'd0 || out_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_regs addr=%0d bank=%0d data=%h exp 0/0/0", mem_rd_addr, mem_rd_bank, out_data);
        end
        checks++;
        if (bank_clear_out !== 6'b111111) begin
            errors++;
            $display("FAIL reset_clear got=%b exp=111111", bank_clear_out);
        end
        reset = 1'b0;
        next_cycle();
    endtask

    task automatic test_basic_drain();
        logic [6:0] exp_f;
        set_bank(4, 6'd9, 1'b1);
        rd_op_id = 6'd9; rd_length = 8'd4; out_ready = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            rd_req = (c == 0);
            #1;
            exp_f = {c == 1, c == 9, 1'b0, c >= 1 && c <= 9, c >= 2 && c <= 5, c >= 4 && c <= 7, c == 7};
            checks++;
            if ({rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last} !== exp_f) begin
                errors++;
                $display("FAIL basic_flags c=%0d got=%b exp=%b", c,
                         {rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last}, exp_f);
            end
            if (c >= 2 && c <= 6) begin
                checks++;
                if (mem_rd_addr !== 8'(c - 2) || mem_rd_bank !== 3'd4) begin
                    errors++;
                    $display("FAIL basic_addr c=%0d addr=%0d bank=%0d exp addr=%0d bank=4", c, mem_rd_addr, mem_rd_bank, c - 2);
                end
            end
            if (c >= 4 && c <= 7) begin
                checks++;
                if (out_data !== pat(3'd4, 8'(c - 4))) begin
                    errors++;
                    $display("FAIL basic_data c=%0d got=%h exp=%h", c, out_data, pat(3'd4, 8'(c - 4)));
                end
            end
            checks++;
            if (bank_clear_out !== ((c == 8) ? 6'b101111 : 6'b111111)) begin
                errors++;
                $display("FAIL basic_clear c=%0d got=%b exp=%b", c, bank_clear_out, (c == 8) ? 6'b101111 : 6'b111111);
            end
            next_cycle();
        end
        rd_req = 1'b0;
    endtask

    task automatic test_error(input logic [5:0] op, input logic [7:0] len);
        logic [4:0] exp_f;
        rd_op_id = op; rd_length = len; out_ready = 1'b1;
        for (int c = 0; c <= 3; c++) begin
            rd_req = (c == 0);
            #1;
            exp_f = {c == 1, c == 2, c == 2, c == 1 || c == 2, 1'b0};
            checks++;
            if ({rd_ack, rd_done, rd_error, busy, mem_rd_en} !== exp_f || bank_clear_out !== 6'b111111) begin
                errors++;
                $display("FAIL error_path op=%0d len=%0d c=%0d got=%b clr=%b exp=%b clr=111111",
                         op, len, c, {rd_ack, rd_done, rd_error, busy, mem_rd_en}, bank_clear_out, exp_f);
            end
            next_cycle();
        end
        rd_req = 1'b0;
    endtask

    // mode 0: out_ready held 1; mode 1: out_ready toggles 1,0,1,0...
    task automatic test_drain(input logic [5:0] op, input int len, input int mode, input logic [2:0] bank);
        int issued = 0, recv = 0, clears = 0;
        logic done = 1'b0, stall_prev = 1'b0;
        logic [31:0] held = '0;
        rd_op_id = op; rd_length = 8'(len);
        for (int c = 0; c < 300 && !done; c++) begin
            rd_req    = (c == 0);
            out_ready = (mode == 0) ? 1'b1 : (c % 2 == 0);
            #1;
            checks++;
            if (issued - recv > 2) begin
                errors++;
                $display("FAIL drain_outstanding c=%0d got=%0d exp<=2", c, issued - recv);
            end
            if (stall_prev) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== held) begin
                    errors++;
                    $display("FAIL drain_stable c=%0d valid=%b data=%h exp valid=1 data=%h", c, out_valid, out_data, held);
                end
            end
            if (mem_rd_en) begin
                checks++;
                if (mem_rd_addr !== 8'(issued) || mem_rd_bank !== bank) begin
                    errors++;
                    $display("FAIL drain_issue addr=%0d bank=%0d exp addr=%0d bank=%0d", mem_rd_addr, mem_rd_bank, issued, bank);
                end
                issued++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (out_data !== pat(bank, 8'(recv)) || out_last !== (recv == len - 1)) begin
                    errors++;
                    $display("FAIL drain_word idx=%0d data=%h last=%b exp data=%h last=%b",
                             recv, out_data, out_last, pat(bank, 8'(recv)), recv == len - 1);
                end
                recv++;
            end
            stall_prev = out_valid && !out_ready;
            held       = out_data;
            if (bank_clear_out !== 6'b111111) begin
                checks++;
                clears++;
                if (bank_clear_out !== ~(6'b000001 << bank)) begin
                    errors++;
                    $display("FAIL drain_clear got=%b exp=%b", bank_clear_out, ~(6'b000001 << bank));
                end
            end
            if (rd_done) begin
                done = 1'b1;
                checks++;
                if (rd_error !== 1'b0 || recv != len || issued != len || clears != 1 ||
                    (mode == 0 && c != len + 5)) begin
                    errors++;
                    $display("FAIL drain_done c=%0d err=%b recv=%0d issued=%0d clears=%0d exp err=0 n=%0d clears=1",
                             c, rd_error, recv, issued, clears, len);
                end
            end
            next_cycle();
        end
        rd_req = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drain_timeout got=no_done exp=done len=%0d", len);
        end
    endtask

    task automatic test_reset_mid_drain();
        int xfers = 0;
        rd_op_id = 6'd9; rd_length = 8'd8; out_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            rd_req = (c == 0);
            #1;
            if (out_valid && out_ready) xfers++;
            next_cycle();
        end
        rd_req = 1'b0;
        checks++;
        if (xfers != 2) begin
            errors++;
            $display("FAIL midrst_xfers got=%0d exp=2", xfers);
        end
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if ({rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last} !== 7'b0 ||
            mem_rd_addr !== 8'd0 || mem_rd_bank !== 3'd0 || out_data !== 32'd0 || bank_clear_out !== 6'b111111) begin
            errors++;
            $display("FAIL midrst_state flags=%b addr=%0d bank=%0d data=%h clr=%b exp all reset values",
                     {rd_ack, rd_done, rd_error, busy, mem_rd_en, out_valid, out_last},
                     mem_rd_addr, mem_rd_bank, out_data, bank_clear_out);
        end
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (rd_done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0 || bank_clear_out !== 6'b111111) begin
                errors++;
                $display("FAIL midrst_quiet c=%0d done=%b busy=%b valid=%b clr=%b exp 0/0/0/111111",
                         c, rd_done, busy, out_valid, bank_clear_out);
            end
            next_cycle();
        end
        test_drain(6'd9, 4, 0, 3'd4);
    endtask

    initial begin
        test_reset();
        test_basic_drain();
        set_bank(1, 6'd3, 1'b1);
        set_bank(2, 6'd3, 1'b1);
        test_drain(6'd3, 4, 0, 3'd1);
        test_error(6'd5, 8'd4);
        test_error(6'd9, 8'd0);
        set_bank(0, 6'd2, 1'b1);
        test_error(6'd2, 8'd17);
        test_drain(6'd2, 16, 0, 3'd0);
        test_drain(6'd9, 8, 1, 3'd4);
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
